fifo_buffer_ext: RTL and testbench

Parametrised synchronous FIFO with its own storage, for the datapath between producer and consumer modules in the lab designs. It replaces the control-only FIFO, which had a fixed-size count and took its data from outside. This block adds:
- a true occupancy count covering the full range,
- almost-full and almost-empty thresholds,
- sticky overflow and underflow error flags,
- defined behaviour for simultaneous read and write,
- a compile-time first-word-fall-through (FWFT) mode.

---
 rtl/fifo_buffer_ext.sv | 118 +++++++++++
 tb/tb_fifo_buffer_ext.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_buffer_ext.sv
// Parametrised synchronous FIFO with internal storage, occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise readValue is registered on pop.
module fifo_buffer_ext #(
  parameter int depth             = 4,
  parameter int width             = 8,
  parameter int almostFullThresh  = 2**depth - 2,
  parameter int almostEmptyThresh = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [width-1:0] writeValue,
  input  logic             read,
  input  logic             clearErr,
  output logic [width-1:0] readValue,
  output logic             readValid,
  output logic             empty,
  output logic             full,
  output logic             almostEmpty,
  output logic             almostFull,
  output logic [depth:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int               ENTRIES  = 2**depth;
  localparam logic [depth:0]   FULL_CNT = (depth+1)'(ENTRIES);
  localparam logic [depth:0]   AF_TH    = (depth+1)'(almostFullThresh);
  localparam logic [depth:0]   AE_TH    = (depth+1)'(almostEmptyThresh);
  localparam logic [depth:0]   CNT_ONE  = (depth+1)'(1'b1);
  localparam logic [depth-1:0] PTR_ONE  = depth'(1'b1);

  logic [width-1:0] mem_r [ENTRIES];
  logic [depth-1:0] write_ptr_r;
  logic [depth-1:0] read_ptr_r;
  logic [depth:0]   count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             read_acc_s;
  logic             write_acc_s;
  logic [depth:0]   count_nxt_s;

  assign count       = count_r;
  assign empty       = (count_r == {(depth+1){1'b0}});
  assign full        = (count_r == FULL_CNT);
  assign almostFull  = (count_r >= AF_TH);
  assign almostEmpty = (count_r <= AE_TH);
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

  // Acceptance and next occupancy; a full FIFO still takes a write when a read frees a slot
  always_comb begin
    read_acc_s  = 1'b0;
    write_acc_s = 1'b0;
    count_nxt_s = count_r;
    read_acc_s  = read && !empty;
    write_acc_s = write && (!full || read_acc_s);
    case ({write_acc_s, read_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_ptr_r <= {depth{1'b0}};
      read_ptr_r  <= {depth{1'b0}};
      count_r     <= {(depth+1){1'b0}};
    end else begin
      if (write_acc_s) write_ptr_r <= write_ptr_r + PTR_ONE;
      if (read_acc_s)  read_ptr_r  <= read_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
    end
  end

  // Sticky error flags; a new error wins over clearErr in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (write && !write_acc_s) overflow_r <= 1'b1;
      else if (clearErr)         overflow_r <= 1'b0;
      if (read && !read_acc_s)   underflow_r <= 1'b1;
      else if (clearErr)         underflow_r <= 1'b0;
    end
  end

  // Storage array, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (write_acc_s) mem_r[write_ptr_r] <= writeValue;
  end

`ifdef FIFO_FWFT_EN
  assign readValue = mem_r[read_ptr_r];
  assign readValid = !empty;
`else
  logic [width-1:0] read_value_r;
  logic             read_valid_r;

  assign readValue = read_value_r;
  assign readValid = read_valid_r;

  // Registered pop data; readValid pulses for exactly the cycle after an accepted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_value_r <= {width{1'b0}};
      read_valid_r <= 1'b0;
    end else begin
      read_valid_r <= read_acc_s;
      if (read_acc_s) read_value_r <= mem_r[read_ptr_r];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_buffer_ext.sv
// Self-checking bench for fifo_buffer_ext: queue-based reference model compared every cycle,
// plus directed literal expectations from the test plan.
module tb_fifo_buffer_ext;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic [7:0] writeValue;
  logic       read;
  logic       clearErr;
  logic [7:0] readValue;
  logic       readValid;
  logic       empty;
  logic       full;
  logic       almostEmpty;
  logic       almostFull;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_udf;
  logic [7:0] m_rv;
  logic       m_rvalid;

  always #5 clk = ~clk;

  fifo_buffer_ext #(
    .depth(2), .width(8), .almostFullThresh(3), .almostEmptyThresh(1)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .writeValue(writeValue),
    .read(read), .clearErr(clearErr), .readValue(readValue), .readValid(readValid),
    .empty(empty), .full(full), .almostEmpty(almostEmpty), .almostFull(almostFull),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_rv     = 8'h00;
    m_rvalid = 1'b0;
  endtask

  // One rising edge of the specification's rules, using the inputs presented at that edge
  task automatic model_edge();
    bit rd_ok;
    bit wr_ok;
    rd_ok = read && (q.size() > 0);
    wr_ok = write && ((q.size() < 4) || rd_ok);
    if (rd_ok) m_rv = q.pop_front();
    m_rvalid = rd_ok;
    if (wr_ok) q.push_back(writeValue);
    if (write && !wr_ok) m_ovf = 1'b1;
    else if (clearErr)   m_ovf = 1'b0;
    if (read && !rd_ok)  m_udf = 1'b1;
    else if (clearErr)   m_udf = 1'b0;
  endtask

  task automatic step(input logic w, input logic [7:0] wv, input logic r, input logic ce);
    write      = w;
    writeValue = wv;
    read       = r;
    clearErr   = ce;
    @(posedge clk);
    model_edge();
    #1;
    write    = 1'b0;
    read     = 1'b0;
    clearErr = 1'b0;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("count",       {29'd0, count}, q.size());
      check("empty",       {31'd0, empty}, {31'd0, q.size() == 0});
      check("full",        {31'd0, full}, {31'd0, q.size() == 4});
      check("almostFull",  {31'd0, almostFull}, {31'd0, q.size() >= 3});
      check("almostEmpty", {31'd0, almostEmpty}, {31'd0, q.size() <= 1});
      check("overflow",    {31'd0, overflow}, {31'd0, m_ovf});
      check("underflow",   {31'd0, underflow}, {31'd0, m_udf});
`ifdef FIFO_FWFT_EN
      check("readValid",   {31'd0, readValid}, {31'd0, q.size() > 0});
      if (q.size() > 0) check("readValue", {24'd0, readValue}, {24'd0, q[0]});
`else
      check("readValid",   {31'd0, readValid}, {31'd0, m_rvalid});
      check("readValue",   {24'd0, readValue}, {24'd0, m_rv});
`endif
    end
  end

  initial begin
    logic [7:0] fill_data [4];
    fill_data[0] = 8'h11; fill_data[1] = 8'h22; fill_data[2] = 8'h33; fill_data[3] = 8'h44;
    reset = 1'b1; write = 1'b0; writeValue = 8'h00; read = 1'b0; clearErr = 1'b0;
    model_reset();
    #12;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full}, 32'd0);
    reset   = 1'b0;
    started = 1'b1;

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill_data[i], 1'b0, 1'b0);
      if (i == 2) check("af_at_3", {31'd0, almostFull}, 32'd1);
      if (i == 2) check("nfull_at_3", {31'd0, full}, 32'd0);
    end
    check("full_at_4", {31'd0, full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
      check("drain_val", {24'd0, readValue}, {24'd0, fill_data[i]});
      check("drain_vld", {31'd0, readValid}, 32'd1);
`endif
    end
    check("drained_empty", {31'd0, empty}, 32'd1);

    // Overflow, sticky, clear, and no corruption of the head
    for (int i = 0; i < 4; i++) step(1'b1, fill_data[i], 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovf_count", {29'd0, count}, 32'd4);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clear", {31'd0, overflow}, 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    check("ovf_head", {24'd0, readValue}, 32'h11);
`endif
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, observed before the next clock edge
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("amid_count", {29'd0, count}, 32'd0);
    check("amid_empty", {31'd0, empty}, 32'd1);
    check("amid_ae",    {31'd0, almostEmpty}, 32'd1);
    check("amid_ovf",   {31'd0, overflow}, 32'd0);
`ifndef FIFO_FWFT_EN
    check("amid_rvalid", {31'd0, readValid}, 32'd0);
    check("amid_rvalue", {24'd0, readValue}, 32'd0);
`endif
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Simultaneous read and write when full
    for (int i = 0; i < 4; i++) step(1'b1, fill_data[i], 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    check("rw_full_count", {29'd0, count}, 32'd4);
    check("rw_full_ovf", {31'd0, overflow}, 32'd0);
`ifndef FIFO_FWFT_EN
    check("rw_full_pop", {24'd0, readValue}, 32'h11);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    check("rw_wrapped", {24'd0, readValue}, 32'h66);
`endif

    // Simultaneous read and write when empty
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("rw_empty_count", {29'd0, count}, 32'd1);
    check("rw_empty_udf", {31'd0, underflow}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    check("rw_empty_val", {24'd0, readValue}, 32'h77);
`endif

    // Wrap-around with interleaved pairs
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
      check("wrap_val", {24'd0, readValue}, i);
`endif
    end

`ifdef FIFO_FWFT_EN
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_val", {24'd0, readValue}, 32'hA5);
    check("fwft_vld", {31'd0, readValid}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_empty", {31'd0, empty}, 32'd1);
    check("fwft_nvld", {31'd0, readValid}, 32'd0);
`endif

    @(negedge clk);
    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
